// File: rtl/mux_stream_rr_pkg.sv
// Shared constants and width helper for the round-robin stream multiplexer.
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Channel-index width; never below 1 so a port vector always exists.
  function automatic int calc_sw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mux_stream_rr_if.sv
// Stream bus between the input channels, the multiplexer and the downstream sink.
interface mux_stream_rr_if #(
  parameter int NCH = 8,
  parameter int W   = 8
);
  import mux_pkg::*;
  localparam int SW = calc_sw(NCH);

  logic [NCH-1:0]        in_valid;
  logic [NCH-1:0][W-1:0] in_data;
  logic [NCH-1:0]        in_ready;
  logic                  out_valid;
  logic [W-1:0]          out_data;
  logic [SW-1:0]         out_ch;
  logic                  out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ch
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ch
  );
endinterface

// File: rtl/mux_stream_rr_arbiter.sv
// Round-robin search: first requester strictly after ptr, wrapping at NCH-1.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int NCH = 8,
  parameter int SW  = calc_sw(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [SW-1:0]  ptr,
  output logic [NCH-1:0] gnt,
  output logic [SW-1:0]  idx
);

  logic [SW-1:0] w_k;
  logic          w_found;

  always_comb begin
    gnt     = '0;
    idx     = '0;
    w_found = 1'b0;
    w_k     = '0;
    // ptr itself is visited last (i == NCH), giving it lowest priority.
    for (int i = 1; i <= NCH; i++) begin
      w_k = SW'((int'(ptr) + i) % NCH);
      if (!w_found && req[w_k]) begin
        w_found  = 1'b1;
        gnt[w_k] = 1'b1;
        idx      = w_k;
      end
    end
  end

endmodule

// File: rtl/mux_stream_rr.sv
// N-channel stream multiplexer, fixed-select or round-robin, single output register.
module mux_stream_rr
  import mux_pkg::*;
#(
  parameter int NCH = 8,
  parameter int W   = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     E,
  input  logic                     mode,
  input  logic [calc_sw(NCH)-1:0]  s,
  mux_stream_rr_if.slave           bus
);

  localparam int SW = calc_sw(NCH);

  logic          r_valid;
  logic [W-1:0]  r_data;
  logic [SW-1:0] r_ch;
  logic [SW-1:0] r_ptr;

  logic [NCH-1:0] w_rr_gnt;
  logic [SW-1:0]  w_rr_idx;
  logic           w_fix_ok;
  logic           w_sel_ok;
  logic [SW-1:0]  w_sel_idx;
  logic [W-1:0]   w_sel_data;
  logic           w_out_xfer;
  logic           w_in_xfer;
  logic [NCH-1:0] w_rdy;

  rr_arbiter #(.NCH(NCH), .SW(SW)) u_arb (
    .req (bus.in_valid),
    .ptr (r_ptr),
    .gnt (w_rr_gnt),
    .idx (w_rr_idx)
  );

  // Out-of-range s grants nothing; the bound check also guards the in_valid index.
  assign w_fix_ok   = (int'(s) < NCH) && bus.in_valid[s];
  assign w_sel_ok   = (mode == MODE_RR) ? |w_rr_gnt : w_fix_ok;
  assign w_sel_idx  = (mode == MODE_RR) ? w_rr_idx : s;
  assign w_sel_data = bus.in_data[w_sel_idx];

  assign w_out_xfer = r_valid && bus.out_ready;
  // rst_n gates the grant so in_ready stays low throughout reset.
  assign w_in_xfer  = rst_n && E && w_sel_ok && (!r_valid || bus.out_ready);

  for (genvar k = 0; k < NCH; k++) begin : g_rdy
    assign w_rdy[k] = w_in_xfer && (w_sel_idx == SW'(k));
  end

  assign bus.in_ready  = w_rdy;
  assign bus.out_valid = r_valid;
  assign bus.out_data  = r_data;
  assign bus.out_ch    = r_ch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_ch    <= '0;
      r_ptr   <= SW'(NCH - 1);
    end else begin
      if (w_in_xfer) begin
        r_valid <= 1'b1;
        r_data  <= w_sel_data;
        r_ch    <= w_sel_idx;
      end else if (w_out_xfer) begin
        r_valid <= 1'b0;
      end
      if (w_in_xfer && (mode == MODE_RR)) r_ptr <= w_rr_idx;
    end
  end

endmodule

// File: tb/tb_mux_stream_rr.sv
// Directed scenarios plus randomized traffic against a queue-based reference model.
module tb_mux_stream_rr;
  import mux_pkg::*;

  localparam int NCH = 8;
  localparam int W   = 8;
  localparam int SW  = calc_sw(NCH);

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          E     = 1'b0;
  logic          mode  = MODE_FIXED;
  logic [SW-1:0] s     = '0;

  mux_stream_rr_if #(.NCH(NCH), .W(W)) bus ();

  mux_stream_rr #(.NCH(NCH), .W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .E     (E),
    .mode  (mode),
    .s     (s),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int           ch;
    logic [W-1:0] d;
  } word_t;

  word_t q[$];
  int    mptr = NCH - 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int grant_of(input logic m, input int sel, input logic [NCH-1:0] v,
                                  input int p);
    if (m == MODE_FIXED) return (sel < NCH && v[sel]) ? sel : -1;
    for (int i = 1; i <= NCH; i++)
      if (v[(p + i) % NCH]) return (p + i) % NCH;
    return -1;
  endfunction

  // Reference model: at most one word held; checked and advanced once per cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_data", bus.out_data, 0);
      chk("rst_out_ch", bus.out_ch, 0);
      chk("rst_in_ready", bus.in_ready, 0);
      q.delete();
      mptr = NCH - 1;
    end else begin : model
      int             g;
      logic [NCH-1:0] er;
      word_t          w;
      chk("out_valid", bus.out_valid, q.size() != 0);
      if (q.size() != 0) begin
        chk("out_data", bus.out_data, q[0].d);
        chk("out_ch", bus.out_ch, q[0].ch);
      end
      g  = grant_of(mode, int'(s), bus.in_valid, mptr);
      er = '0;
      if (E && g >= 0 && (q.size() == 0 || bus.out_ready)) er[g] = 1'b1;
      chk("in_ready", bus.in_ready, er);
      if (q.size() != 0 && bus.out_ready) void'(q.pop_front());
      if (er != 0) begin
        w.ch = g;
        w.d  = bus.in_data[g];
        q.push_back(w);
        if (mode == MODE_RR) mptr = g;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  initial begin
    bus.in_valid  = '0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;

    // Fixed select of channel 3
    E = 1'b1; mode = MODE_FIXED; s = 3;
    bus.in_data[3] = 8'hBB; bus.in_valid = 8'b00001000; bus.out_ready = 1'b1;
    at_neg(); chk("fix_in_ready", bus.in_ready, 8'b00001000);
    at_neg(); chk("fix_valid", bus.out_valid, 1);
    chk("fix_data", bus.out_data, 8'hBB);
    chk("fix_ch", bus.out_ch, 3);

    // Stall with a held word, then drain and refill in one cycle
    step(); s = 2; bus.in_data[2] = 8'h5A; bus.in_valid = 8'b00000100;
    step(); bus.out_ready = 1'b0; bus.in_data[2] = 8'hA5;
    for (int i = 0; i < 5; i++) begin
      at_neg();
      chk("stall_in_ready", bus.in_ready, 0);
      chk("stall_data", bus.out_data, 8'h5A);
    end
    step(); bus.out_ready = 1'b1;
    at_neg(); chk("refill_in_ready", bus.in_ready, 8'b00000100);
    at_neg(); chk("refill_valid", bus.out_valid, 1);
    chk("refill_data", bus.out_data, 8'hA5);

    // Enable low: held word drains, nothing new granted
    step(); E = 1'b0;
    at_neg(); chk("dis_in_ready", bus.in_ready, 0);
    at_neg(); chk("dis_drained", bus.out_valid, 0);
    at_neg(); chk("dis_idle", bus.out_valid, 0);

    // Round-robin stream, then an asynchronous reset mid-stream
    step(); E = 1'b1; mode = MODE_RR; bus.in_valid = 8'hFF;
    for (int k = 0; k < NCH; k++) bus.in_data[k] = W'(8'h10 + k);
    step(); step();
    rst_n = 1'b0; #1;
    chk("async_rst_valid", bus.out_valid, 0);
    step(); rst_n = 1'b1;
    at_neg(); chk("rr_first_grant", bus.in_ready, 8'b00000001);
    for (int i = 0; i < 9; i++) begin
      at_neg();
      chk("rr_seq_ch", bus.out_ch, i % NCH);
      chk("rr_seq_data", bus.out_data, 8'h10 + (i % NCH));
    end

    // Sparse requesters 7 and 1 with ptr at 1
    step(); bus.in_valid = 8'b10000010;
    at_neg(); chk("rr_sparse_ch0", bus.out_ch, 1);
    at_neg(); chk("rr_sparse_ch1", bus.out_ch, 7);
    at_neg(); chk("rr_sparse_ch2", bus.out_ch, 1);
    at_neg(); chk("rr_sparse_ch3", bus.out_ch, 7);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      step();
      E    = ($urandom_range(0, 9) != 0);
      mode = ($urandom_range(0, 7) == 0) ? MODE_FIXED : MODE_RR;
      if ($urandom_range(0, 3) == 0) s = SW'($urandom_range(0, NCH - 1));
      bus.in_valid = ($urandom_range(0, 2) == 0) ? NCH'($urandom)
                                                 : NCH'($urandom) & NCH'($urandom);
      for (int k = 0; k < NCH; k++) bus.in_data[k] = W'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      rst_n = ($urandom_range(0, 199) != 0);
    end
    step(); rst_n = 1'b1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_stream_rr.md
MUX_STREAM_RR -- requirements
Module: mux_stream_rr

Interface
REQ-001 Parameter NCH, default 8, SHALL set the number of input channels; legal range 2..32.
REQ-002 Parameter W, default 8, SHALL set the data width per channel; legal range 1..64.
REQ-003 Derived constant SW = $clog2(NCH) SHALL set the width of channel-index signals.
REQ-004 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-005 rst_n  input  1  SHALL be the reset, asynchronous and active-low.
REQ-006 E  input  1  SHALL be the enable; when 0, no new channel is granted.
REQ-007 mode  input  1  SHALL select 0 = fixed select (channel s), 1 = round-robin.
REQ-008 s  input  SW  SHALL be the fixed-mode channel select.
REQ-009 in_valid  input  NCH  SHALL carry the per-channel data-valid flags.
REQ-010 in_data  input  NCH*W  SHALL carry channel k data in bits [k*W +: W].
REQ-011 in_ready  output  NCH  SHALL carry the per-channel accept strobes.
REQ-012 out_valid  output  1  SHALL indicate that the output register holds data.
REQ-013 out_data  output  W  SHALL carry the registered data.
REQ-014 out_ch  output  SW  SHALL carry the source channel index of out_data.
REQ-015 out_ready  input  1  SHALL indicate that the downstream accepts data.

Function
REQ-016 Transfer rules: an input transfer on channel k SHALL occur when in_valid[k] and in_ready[k] are both 1; an output transfer SHALL occur when out_valid and out_ready are both 1.
REQ-017 One-hot grant: at most one in_ready bit SHALL be 1 per cycle.
REQ-018 Grant conditions: in_ready[k] SHALL be 1 only when all of the following hold:
- E = 1;
- k is the granted channel;
- in_valid[k] = 1;
- the output register is empty, or an output transfer occurs in the same cycle.
REQ-019 Fixed mode: the granted channel SHALL be s; an s value >= NCH SHALL grant no channel.
REQ-020 Round-robin mode: the granted channel SHALL be the first channel with in_valid = 1, searching upward from ptr+1 with wrap-around from NCH-1 to 0.
REQ-021 Round-robin pointer:
- ptr SHALL load the granted index only on an input transfer;
- ptr SHALL NOT change in fixed mode.
REQ-022 Input-transfer latency: on an input transfer, out_data and out_ch SHALL update on the next edge and out_valid SHALL be 1 (one-cycle latency).
REQ-023 Simultaneous transfers: an output transfer and an input transfer in the same cycle SHALL replace the register contents with no bubble, sustaining 1 word per cycle.
REQ-024 Output-only transfer: an output transfer with no input transfer SHALL clear out_valid on the next edge.
REQ-025 Stall hold: while out_valid = 1 and out_ready = 0, out_data and out_ch SHALL remain stable.
REQ-026 Enable deasserted: E = 0 SHALL NOT block draining of a held word.
REQ-027 Mode or s change: a change of mode or s SHALL take effect for the next grant decision; a held word SHALL be unaffected.
REQ-028 No valid input: with no in_valid bit set, in_ready SHALL be all 0 and ptr SHALL hold.

Reset
REQ-029 While rst_n = 0, the block SHALL hold:
- out_valid = 0;
- out_data = 0;
- out_ch = 0;
- in_ready = 0;
- ptr = NCH-1, so channel 0 has first priority.
REQ-030 Mid-operation reset: reset asserted mid-operation SHALL discard any held word immediately, with no output transfer.
REQ-031 Reset release: the first grant SHALL occur on the first rising edge after rst_n deasserts.

Structure
REQ-032 Package mux_pkg SHALL hold:
- mode constants MODE_FIXED = 1'b0 and MODE_RR = 1'b1;
- the SW derivation function.
REQ-033 Arbiter sub-module: the round-robin search SHALL be a sub-module rr_arbiter (inputs req, ptr; output one-hot gnt and index); the datapath SHALL be mux-selected by that index.
REQ-034 The design SHALL contain no latches, and all outputs SHALL be driven from registers or from logic combinational in the current inputs and state.

Verification
REQ-035 Scenario: NCH=8, W=8, mode=0, E=1, s=3, in_data ch3 = 8'hBB, in_valid = 8'b00001000, out_ready = 1 -> in_ready = 8'b00001000; next cycle out_valid = 1, out_data = 8'hBB, out_ch = 3.
REQ-036 Scenario: mode=1, in_valid = 8'hFF held, out_ready = 1 from reset -> out_ch sequence 0,1,2,...,7,0, one word per cycle.
REQ-037 Scenario: mode=1, in_valid = 8'b10000010, ptr = 1 -> grant 7, then 1, then 7.
REQ-038 Scenario: out_ready = 0 for 5 cycles with a word held -> in_ready = 0 and out_data stable; on out_ready = 1, drain and refill occur in the same cycle.
REQ-039 Scenario: E=0 with a word held and out_ready = 1 -> word drains, then out_valid = 0 and no further grants.
REQ-040 Scenario: rst_n pulsed low mid-stream -> out_valid = 0 asynchronously; after release the first round-robin grant goes to channel 0.
